// File: rtl/fir_ntap_pipe.sv
// fir_ntap_pipe: N-tap signed direct-form FIR, loadable coefficients, registered products, pipelined adder tree.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   x, in_valid       signed input sample and its qualifier
//   coef_wr_en/addr/wdata  coefficient write port (addr 0 = newest sample)
//   y, out_valid      full-precision signed output, valid LAT edges after accept
module fir_ntap_pipe #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int ADDR_W = $clog2(TAPS),
    parameter int OUT_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] x,
    input  logic                     in_valid,
    input  logic                     coef_wr_en,
    input  logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic signed [OUT_W-1:0]  y,
    output logic                     out_valid
);
    localparam int PW  = DATA_W + COEF_W;
    localparam int LAT = $clog2(TAPS) + 2;

    logic signed [DATA_W-1:0] xd_q     [TAPS];
    logic signed [COEF_W-1:0] coef_q   [TAPS];
    logic signed [COEF_W-1:0] coef_p_q [TAPS];
    logic signed [PW-1:0]     p_q      [TAPS];
    logic signed [OUT_W-1:0]  sum_q    [1:TAPS-1];
    logic signed [OUT_W-1:0]  node     [1:2*TAPS-1];
    logic        [LAT:0]      vld_q, vld_d;
    logic signed [OUT_W-1:0]  y_q, y_d;

    // Heap-ordered tree: node i = node 2i + node 2i+1, leaves are the products.
    // Every internal node is a register, so each tree level is one pipeline stage.
    always_comb begin
        for (int i = 1; i < TAPS; i++) node[i] = sum_q[i];
        for (int k = 0; k < TAPS; k++) node[TAPS+k] = OUT_W'(p_q[k]);
    end

    // Bit j of vld_q holds in_valid sampled j edges ago; bit LAT is out_valid.
    assign vld_d = {vld_q[LAT-1:0], in_valid};
    assign y_d   = vld_q[LAT-1] ? node[1] : y_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                xd_q[k]     <= '0;
                coef_q[k]   <= '0;
                coef_p_q[k] <= '0;
                p_q[k]      <= '0;
            end
            for (int i = 1; i < TAPS; i++) sum_q[i] <= '0;
            vld_q <= '0;
            y_q   <= '0;
        end else begin
            if (in_valid) begin
                xd_q[0] <= x;
                for (int k = 1; k < TAPS; k++) xd_q[k] <= xd_q[k-1];
            end
            if (coef_wr_en) coef_q[coef_addr] <= coef_wdata;
            // Products are formed one edge after the shift, so they multiply by a
            // copy of the coefficients taken before any write on the accept edge.
            for (int k = 0; k < TAPS; k++) begin
                coef_p_q[k] <= coef_q[k];
                p_q[k]      <= PW'(xd_q[k]) * PW'(coef_p_q[k]);
            end
            for (int i = 1; i < TAPS; i++) sum_q[i] <= node[2*i] + node[2*i+1];
            vld_q <= vld_d;
            y_q   <= y_d;
        end
    end

    assign y         = y_q;
    assign out_valid = vld_q[LAT];
endmodule

// File: tb/tb_fir_ntap_pipe.sv
// tb_fir_ntap_pipe: directed and random checks of fir_ntap_pipe against a sample-history reference model.
module tb_fir_ntap_pipe;
    localparam int LAT = 6;

    logic               clk = 1'b0;
    logic               reset, in_valid, coef_wr_en, out_valid;
    logic signed [15:0] x, coef_wdata;
    logic        [3:0]  coef_addr;
    logic signed [35:0] y;

    always #5 clk = ~clk;

    fir_ntap_pipe dut (
        .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .y(y), .out_valid(out_valid)
    );

    typedef struct {bit v; longint val;} ent_t;

    longint coef_m [16];
    longint hist   [16];
    ent_t   pipe   [$];
    longint y_m;
    bit     ov_m;
    int     n_chk = 0;
    int     n_fail = 0;
    int     gap_v [11] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    longint gap_x [5]  = '{1, 0, 2, 0, 3};
    longint gap_y [5]  = '{1, 1, 4, 4, 10};

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge: drive inputs, advance the reference model, check outputs.
    task automatic tick(input bit r, input bit iv, input longint xv,
                        input bit we = 0, input int a = 0, input longint wd = 0);
        ent_t e, f;
        reset = r; in_valid = iv; x = 16'(xv);
        coef_wr_en = we; coef_addr = 4'(a); coef_wdata = 16'(wd);
        @(posedge clk);
        if (r) begin
            foreach (hist[k]) begin hist[k] = 0; coef_m[k] = 0; end
            pipe.delete();
            repeat (LAT) pipe.push_back('{0, 0});
            y_m = 0; ov_m = 0;
        end else begin
            e.v = iv; e.val = 0;
            if (iv) begin
                for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = xv;
                foreach (hist[k]) e.val += coef_m[k] * hist[k];
            end
            if (we) coef_m[a] = wd;
            pipe.push_back(e);
            f = pipe.pop_front();
            ov_m = f.v;
            if (f.v) y_m = f.val;
        end
        #1;
        chk("out_valid_model", out_valid, ov_m);
        chk("y_model", $signed(y), y_m);
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) tick(0, 0, 0, 1, k, k + 1);
    endtask

    task automatic load_all(input longint v);
        for (int k = 0; k < 16; k++) tick(0, 0, 0, 1, k, v);
    endtask

    initial begin
        logic signed [15:0] r16, w16;
        tick(1, 0, 0);
        chk("reset_y", $signed(y), 0);
        chk("reset_ov", out_valid, 0);

        load_ramp();
        tick(0, 1, 1);
        for (int i = 1; i <= 22; i++) begin
            tick(0, i <= 16, 0);
            if (i == 5) chk("impulse_ov_early", out_valid, 0);
            if (i >= 6 && i <= 21) chk("impulse_y", $signed(y), i - 5);
            if (i == 22) chk("impulse_tail", $signed(y), 0);
        end

        load_all(1);
        for (int i = 0; i <= 22; i++) begin
            tick(0, 1, 1);
            if (i == 6 || i == 21 || i == 22) chk("ramp1", $signed(y), (i - 5 > 16) ? 16 : i - 5);
        end
        for (int i = 0; i <= 22; i++) tick(0, 1, 5);
        chk("ramp5", $signed(y), 80);

        load_all(-32768);
        for (int i = 0; i <= 22; i++) tick(0, 1, -32768);
        chk("neg_extreme", $signed(y), 64'sd17179869184);
        tick(1, 0, 0);
        tick(0, 0, 0, 1, 0, -32768);
        tick(0, 1, 32767);
        for (int i = 1; i <= 6; i++) tick(0, 0, 0);
        chk("mixed_extreme", $signed(y), -64'sd1073709056);
        chk("mixed_extreme_ov", out_valid, 1);

        tick(1, 0, 0);
        load_ramp();
        for (int e = 0; e <= 10; e++) begin
            tick(0, gap_v[e] != 0, (e < 5) ? gap_x[e] : 0);
            if (e >= 6) begin
                chk("gap_ov", out_valid, gap_v[e-6]);
                chk("gap_y", $signed(y), gap_y[e-6]);
            end
        end

        tick(1, 0, 0);
        load_all(1);
        for (int i = 0; i < 22; i++) tick(0, 1, 1);
        tick(0, 1, 1, 1, 0, 3);
        for (int j = 1; j <= 8; j++) begin
            tick(0, 1, 1);
            if (j == 6) chk("collision_old", $signed(y), 16);
            if (j >= 7) chk("collision_new", $signed(y), 18);
        end

        tick(1, 1, 9);
        chk("midreset_y", $signed(y), 0);
        chk("midreset_ov", out_valid, 0);
        load_ramp();
        tick(0, 1, 7);
        for (int i = 1; i <= 6; i++) begin
            tick(0, 0, 0);
            if (i == 5) chk("midreset_ov_early", out_valid, 0);
            if (i == 6) begin
                chk("midreset_ov_rise", out_valid, 1);
                chk("midreset_y_first", $signed(y), 7);
            end
        end

        for (int i = 0; i < 400; i++) begin
            r16 = 16'($urandom);
            w16 = 16'($urandom);
            tick($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, r16,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 15), w16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
